vga_mismatch_monitor: RTL and testbench

Downstream consumer of the dual-lockstep VGA comparator's `MISMATCH` flag. It turns the raw per-cycle mismatch pulse into a filtered, sticky `FAULT` indication using a consecutive-cycle threshold, and accumulates diagnostics: total mismatch cycles, longest run, and a timestamp of the first mismatch. Software reads and clears these through a small AHB-Lite slave register file on the same bus as the VGA peripherals.

---
 rtl/vga_mismatch_monitor.sv | 151 +++++++++++++++
 tb/tb_vga_mismatch_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mismatch_monitor.sv
// Filters the lockstep comparator MISMATCH flag into a sticky FAULT and keeps
// mismatch diagnostics readable and clearable over an AHB-Lite slave port.
module vga_mismatch_monitor #(
   parameter int unsigned THRESHOLD = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        MISMATCH,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        FAULT
);

   typedef enum logic [1:0] {StOk = 2'd0, StSuspect = 2'd1, StFault = 2'd2} state_e;

   localparam logic [15:0] ThreshM1 = 16'(THRESHOLD - 1);

   state_e      state_q;
   logic        fault_q;
   logic        mm_q;
   logic [31:0] cyc_q;
   logic [15:0] run_q, run_d;
   logic [15:0] total_q, total_d;
   logic [15:0] maxrun_q, maxrun_d;
   logic [31:0] first_q, first_d;
   logic        ever_q, ever_d;
   logic        en_q, en_d;
   logic        dph_q, dwr_q;
   logic [1:0]  dad_q;

   logic        ctrl_wr, clr, count_en;
   logic [15:0] run_inc;
   logic        unused_bits;

   assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:2]};

   always_comb begin
      ctrl_wr  = dph_q & dwr_q & HREADY & (dad_q == 2'd3);
      clr      = ctrl_wr & HWDATA[0];
      en_d     = ctrl_wr ? HWDATA[1] : en_q;
      count_en = en_q & mm_q & ~clr;
      run_inc  = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;

      run_d    = run_q;
      total_d  = total_q;
      maxrun_d = maxrun_q;
      first_d  = first_q;
      ever_d   = ever_q;

      if (clr) begin
         run_d    = '0;
         total_d  = '0;
         maxrun_d = '0;
         first_d  = '0;
         ever_d   = 1'b0;
      end else begin
         run_d = count_en ? run_inc : '0;
         if (count_en) begin
            total_d  = (total_q == 16'hFFFF) ? total_q : total_q + 16'd1;
            maxrun_d = (run_inc > maxrun_q) ? run_inc : maxrun_q;
            if (!ever_q) begin
               first_d = cyc_q;
               ever_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         mm_q     <= 1'b0;
         cyc_q    <= '0;
         run_q    <= '0;
         total_q  <= '0;
         maxrun_q <= '0;
         first_q  <= '0;
         ever_q   <= 1'b0;
         en_q     <= 1'b1;
         dph_q    <= 1'b0;
         dwr_q    <= 1'b0;
         dad_q    <= '0;
      end else begin
         mm_q     <= MISMATCH;
         cyc_q    <= cyc_q + 32'd1;
         run_q    <= run_d;
         total_q  <= total_d;
         maxrun_q <= maxrun_d;
         first_q  <= first_d;
         ever_q   <= ever_d;
         en_q     <= en_d;
         if (HREADY) begin
            dph_q <= HSEL & HTRANS[1];
            dwr_q <= HWRITE;
            dad_q <= HADDR[3:2];
         end
      end
   end

   // Filter FSM; FAULT is registered alongside the state so it never glitches.
   always_ff @(posedge HCLK) begin
      if (HRESET || clr) begin
         state_q <= StOk;
         fault_q <= 1'b0;
      end else begin
         unique case (state_q)
            StOk: begin
               if (count_en) begin
                  if (THRESHOLD > 1) begin
                     state_q <= StSuspect;
                  end else begin
                     state_q <= StFault;
                     fault_q <= 1'b1;
                  end
               end
            end
            StSuspect: begin
               if (!count_en) begin
                  state_q <= StOk;
               end else if (run_q == ThreshM1) begin
                  state_q <= StFault;
                  fault_q <= 1'b1;
               end
            end
            StFault: state_q <= StFault;
            default: state_q <= StOk;
         endcase
      end
   end

   always_comb begin
      HRDATA = '0;
      if (dph_q && !dwr_q) begin
         unique case (dad_q)
            2'd0: HRDATA = {26'd0, state_q, 1'b0, ever_q, mm_q, fault_q};
            2'd1: HRDATA = {maxrun_q, total_q};
            2'd2: HRDATA = first_q;
            2'd3: HRDATA = {30'd0, en_q, 1'b0};
         endcase
      end
   end

   assign HREADYOUT = 1'b1;
   assign FAULT     = fault_q;

endmodule

// File: tb/tb_vga_mismatch_monitor.sv
// Bench for vga_mismatch_monitor: two instances (THRESHOLD 4 and 1) on shared
// inputs, checked each cycle against a behavioural model plus literal reads.
module tb_vga_mismatch_monitor;

   logic        HCLK = 1'b0;
   logic        HRESET, MISMATCH, HSEL, HWRITE, HREADY;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic        ro4, ro1, f4, f1;
   logic [31:0] rd4, rd1;

   always #5 HCLK = ~HCLK;

   vga_mismatch_monitor #(.THRESHOLD(4)) u_dut4 (
      .HCLK(HCLK), .HRESET(HRESET), .MISMATCH(MISMATCH), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(ro4), .HRDATA(rd4), .FAULT(f4)
   );

   vga_mismatch_monitor #(.THRESHOLD(1)) u_dut1 (
      .HCLK(HCLK), .HRESET(HRESET), .MISMATCH(MISMATCH), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(ro1), .HRDATA(rd1), .FAULT(f1)
   );

   int total_n = 0;
   int bad_n   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: consecutive-run length, saturating tallies, sticky faults.
   localparam int unsigned ThA = 4;
   localparam int unsigned ThB = 1;
   bit          mv = 1'b0;
   logic        m_mm, m_ever, m_en, m_dph, m_dwr;
   int unsigned m_consec, m_total, m_maxrun;
   logic [31:0] m_first, m_cyc;
   logic        m_fault [2];
   logic [1:0]  m_dad;
   int unsigned edge_no;

   always @(posedge HCLK) begin : model
      logic wr, clr;
      int unsigned th, mr;
      if (HRESET) begin
         mv = 1'b1; m_mm = 1'b0; m_ever = 1'b0; m_en = 1'b1; m_dph = 1'b0; m_dwr = 1'b0;
         m_consec = 0; m_total = 0; m_maxrun = 0; m_first = '0; m_cyc = '0; m_dad = '0;
         m_fault[0] = 1'b0; m_fault[1] = 1'b0;
         edge_no = 0;
      end else begin
         wr  = m_dph && m_dwr && HREADY && (m_dad == 2'd3);
         clr = wr && HWDATA[0];
         if (clr) begin
            m_consec = 0; m_total = 0; m_maxrun = 0; m_first = '0; m_ever = 1'b0;
            m_fault[0] = 1'b0; m_fault[1] = 1'b0;
         end else if (m_en && m_mm) begin
            m_consec++;
            if (m_total < 65535) m_total++;
            mr = (m_consec > 65535) ? 65535 : m_consec;
            if (mr > m_maxrun) m_maxrun = mr;
            if (!m_ever) begin
               m_first = m_cyc;
               m_ever  = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
               th = (i == 0) ? ThA : ThB;
               if (m_consec >= th) m_fault[i] = 1'b1;
            end
         end else begin
            m_consec = 0;
         end
         if (wr) m_en = HWDATA[1];
         m_mm  = MISMATCH;
         m_cyc = m_cyc + 32'd1;
         edge_no++;
         if (HREADY) begin
            m_dph = HSEL && HTRANS[1];
            m_dwr = HWRITE;
            m_dad = HADDR[3:2];
         end
      end
   end

   function automatic logic [31:0] exp_rd(input int i);
      logic [1:0] st;
      st = m_fault[i] ? 2'd2 : ((m_consec > 0) ? 2'd1 : 2'd0);
      if (!(m_dph && !m_dwr)) return 32'd0;
      case (m_dad)
         2'd0:    return {26'd0, st, 1'b0, m_ever, m_mm, m_fault[i]};
         2'd1:    return {16'(m_maxrun), 16'(m_total)};
         2'd2:    return m_first;
         default: return {30'd0, m_en, 1'b0};
      endcase
   endfunction

   always @(negedge HCLK) begin
      if (mv) begin
         chk("model_rd_t4", rd4, exp_rd(0));
         chk("model_rd_t1", rd1, exp_rd(1));
         chk("model_fault_t4", {31'd0, f4}, {31'd0, m_fault[0]});
         chk("model_fault_t1", {31'd0, f1}, {31'd0, m_fault[1]});
         chk("hreadyout_t4", {31'd0, ro4}, 32'd1);
         chk("hreadyout_t1", {31'd0, ro1}, 32'd1);
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] v4, output logic [31:0] v1);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      tick();
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge HCLK);
      v4 = rd4;
      v1 = rd1;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      tick();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      tick();
   endtask

   task automatic pulse(input int n);
      MISMATCH = 1'b1;
      repeat (n) tick();
      MISMATCH = 1'b0;
   endtask

   logic [31:0] v4, v1;
   int unsigned first_exp;

   initial begin
      HRESET = 1'b1; MISMATCH = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HREADY = 1'b1;
      HADDR = '0; HWDATA = '0; HTRANS = 2'b00;
      repeat (3) tick();
      HRESET = 1'b0;

      // Reset values of every register.
      bus_rd(32'h0, v4, v1); chk("rst_status_t4", v4, 32'h0); chk("rst_status_t1", v1, 32'h0);
      bus_rd(32'h4, v4, v1); chk("rst_count_t4", v4, 32'h0);  chk("rst_count_t1", v1, 32'h0);
      bus_rd(32'h8, v4, v1); chk("rst_first_t4", v4, 32'h0);  chk("rst_first_t1", v1, 32'h0);
      bus_rd(32'hC, v4, v1); chk("rst_ctrl_t4", v4, 32'h2);   chk("rst_ctrl_t1", v1, 32'h2);

      // Two 3-cycle bursts stay below threshold 4.
      pulse(3); repeat (3) tick();
      pulse(3); repeat (3) tick();
      chk("short_bursts_fault_t4", {31'd0, f4}, 32'd0);
      bus_rd(32'h4, v4, v1); chk("short_count_t4", v4, 32'h0003_0006);
      chk("short_count_t1", v1, 32'h0003_0006);
      bus_rd(32'h0, v4, v1); chk("short_status_t4", v4, 32'h4); chk("short_status_t1", v1, 32'h25);

      // Exact threshold latency and FIRST capture.
      bus_wr(32'hC, 32'h3);
      MISMATCH = 1'b1;
      tick();
      first_exp = edge_no;
      repeat (3) tick();
      chk("thr_fault_e3", {31'd0, f4}, 32'd0);
      tick();
      chk("thr_fault_e4", {31'd0, f4}, 32'd1);
      MISMATCH = 1'b0;
      repeat (3) tick();
      chk("thr_sticky", {31'd0, f4}, 32'd1);
      bus_rd(32'h8, v4, v1); chk("thr_first", v4, first_exp);

      // CLR while the mismatch is held: CLR wins, counting restarts.
      MISMATCH = 1'b1;
      repeat (2) tick();
      bus_wr(32'hC, 32'h3);
      first_exp = edge_no;
      chk("clr_fault_t4", {31'd0, f4}, 32'd0);
      chk("clr_fault_t1", {31'd0, f1}, 32'd0);
      bus_rd(32'h4, v4, v1); chk("clr_count_restart", v4, 32'h0001_0001);
      MISMATCH = 1'b0;
      bus_rd(32'h8, v4, v1); chk("clr_first_recapture", v4, first_exp);

      // Disabled monitoring ignores mismatches.
      bus_wr(32'hC, 32'h0);
      MISMATCH = 1'b1;
      repeat (4) tick();
      bus_rd(32'h0, v4, v1); chk("dis_status_t4", v4, 32'h6); chk("dis_status_t1", v1, 32'h27);
      repeat (5) tick();
      MISMATCH = 1'b0;
      repeat (2) tick();
      bus_rd(32'h4, v4, v1); chk("dis_count", v4, 32'h0002_0002);
      chk("dis_fault_t4", {31'd0, f4}, 32'd0);
      bus_wr(32'hC, 32'h2);
      bus_rd(32'hC, v4, v1); chk("reen_ctrl", v4, 32'h2);
      pulse(2); repeat (2) tick();
      bus_rd(32'h4, v4, v1); chk("reen_count", v4, 32'h0002_0004);

      // Threshold 1 and counter saturation.
      bus_wr(32'hC, 32'h3);
      MISMATCH = 1'b1;
      tick();
      chk("t1_fault_e0", {31'd0, f1}, 32'd0);
      tick();
      chk("t1_fault_e1", {31'd0, f1}, 32'd1);
      repeat (70000) tick();
      bus_rd(32'h4, v4, v1); chk("sat_count_t4", v4, 32'hFFFF_FFFF);
      chk("sat_count_t1", v1, 32'hFFFF_FFFF);

      // Reset during a read address phase drops the data phase.
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4; HRESET = 1'b1;
      tick();
      HSEL = 1'b0; HTRANS = 2'b00; HRESET = 1'b0; MISMATCH = 1'b0;
      @(negedge HCLK);
      chk("midrst_rdata", rd4, 32'h0);
      chk("midrst_fault_t1", {31'd0, f1}, 32'd0);
      bus_rd(32'hC, v4, v1); chk("midrst_ctrl", v4, 32'h2);
      bus_rd(32'h4, v4, v1); chk("midrst_count", v4, 32'h0);
      tick();

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
